parity_frame_scheduler: RTL and testbench

//  Shares one combinational DATA_W-bit parity-reduction tree between NREQ requesters.

---
 rtl/parity_sched_pkg.sv | 18 +
 rtl/parity_reduce.sv | 32 +++
 rtl/parity_frame_scheduler.sv | 126 ++++++++++++
 tb/tb_parity_frame_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_sched_pkg.sv
// Shared types and sizing helpers for the per-frame parity scheduler.
package parity_sched_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Requester-id width; kept at least 1 bit so ports never collapse to zero width.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parity_reduce.sv
// Purpose: balanced XOR tree reducing one DATA_W word to its even-parity bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module parity_reduce #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    localparam int LEVELS = (DATA_W > 1) ? $clog2(DATA_W) : 0;
    localparam int PW     = 1 << LEVELS;

    // Level k holds PW>>k partial parities; odd widths are zero-padded at the leaves.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        logic [(PW>>k)-1:0] v;
        if (k == 0) begin : g_leaf
            if (PW > DATA_W) begin : g_pad
                assign v = {{(PW-DATA_W){1'b0}}, data};
            end else begin : g_nopad
                assign v = data;
            end
        end else begin : g_node
            for (genvar j = 0; j < (PW>>k); j++) begin : g_xor
                assign v[j] = g_lvl[k-1].v[2*j] ^ g_lvl[k-1].v[2*j+1];
            end
        end
    end

    assign parity = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/parity_frame_scheduler.sv
// Purpose: round-robin per-frame arbitration of NREQ word streams onto one parity tree.
// Latency: one arbitration cycle per frame; result valid the cycle after the last-word accept.
// Backpressure: req_ready only to the granted requester; result held until res_ready.
module parity_frame_scheduler
    import parity_sched_pkg::*;
#(
    parameter int  NREQ       = NREQ_DEF,
    parameter int  DATA_W     = DATA_W_DEF,
    parameter int  CNT_W      = 8,
    parameter bit  ODD_PARITY = 1'b0,
    localparam int ID_W       = id_width(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_parity,
    output logic [ID_W-1:0]          res_id,
    output logic [CNT_W-1:0]         res_words
);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant;
    logic                acc;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;

    logic [2*NREQ-1:0]   arb_rot;
    logic [ID_W-1:0]     arb_off;
    logic [ID_W:0]       arb_sum;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_any;

    logic [DATA_W-1:0]   word;
    logic                word_par;
    logic                accept;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then un-rotate modulo NREQ.
    always_comb begin
        arb_rot = {req_valid, req_valid} >> rr_ptr;
        arb_any = |req_valid;
        arb_off = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (arb_rot[k]) arb_off = ID_W'(k);
        end
        arb_sum = {1'b0, rr_ptr} + {1'b0, arb_off};
        if (arb_sum >= (ID_W+1)'(NREQ)) arb_sum = arb_sum - (ID_W+1)'(NREQ);
        arb_idx = arb_sum[ID_W-1:0];
    end

    always_comb begin
        word = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == ID_W'(k)) word = req_data[k*DATA_W +: DATA_W];
        end
    end

    parity_reduce #(.DATA_W(DATA_W)) u_reduce (
        .data   (word),
        .parity (word_par)
    );

    assign accept  = (state == BUSY) && req_valid[grant];
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: if (arb_any) state_nxt = BUSY;
            BUSY: begin
                req_ready[grant] = 1'b1;
                if (accept && req_last[grant]) state_nxt = HOLD;
            end
            HOLD: if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            grant      <= '0;
            acc        <= 1'b0;
            cnt        <= '0;
            res_valid  <= 1'b0;
            res_parity <= 1'b0;
            res_id     <= '0;
            res_words  <= '0;
        end else begin
            case (state)
                IDLE: if (arb_any) begin
                    grant <= arb_idx;
                    acc   <= 1'b0;
                    cnt   <= '0;
                end
                BUSY: if (accept) begin
                    acc <= acc ^ word_par;
                    cnt <= cnt_inc;
                    if (req_last[grant]) begin
                        res_parity <= acc ^ word_par ^ ODD_PARITY;
                        res_id     <= grant;
                        res_words  <= cnt_inc;
                        res_valid  <= 1'b1;
                    end
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    rr_ptr    <= (res_id == ID_W'(NREQ-1)) ? '0 : res_id + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_scheduler.sv
// Directed frames into two scheduler instances (default, and CNT_W=2 with odd parity);
// expected results are queued at issue time and popped by monitors on each result handshake.
module tb_parity_frame_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 16;

    typedef struct {
        int id;
        int words;
        int par;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NREQ-1:0]      valid [2];
    logic [NREQ-1:0]      last  [2];
    logic [NREQ*DW-1:0]   data  [2];
    logic                 res_ready [2];

    logic [NREQ-1:0]      a_ready, b_ready;
    logic                 a_res_valid, b_res_valid;
    logic                 a_res_parity, b_res_parity;
    logic [1:0]           a_res_id, b_res_id;
    logic [7:0]           a_words;
    logic [1:0]           b_words;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    parity_frame_scheduler #(.NREQ(NREQ), .DATA_W(DW), .CNT_W(8), .ODD_PARITY(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid[0]), .req_data(data[0]), .req_last(last[0]), .req_ready(a_ready),
        .res_valid(a_res_valid), .res_ready(res_ready[0]), .res_parity(a_res_parity),
        .res_id(a_res_id), .res_words(a_words)
    );

    parity_frame_scheduler #(.NREQ(NREQ), .DATA_W(DW), .CNT_W(2), .ODD_PARITY(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid[1]), .req_data(data[1]), .req_last(last[1]), .req_ready(b_ready),
        .res_valid(b_res_valid), .res_ready(res_ready[1]), .res_parity(b_res_parity),
        .res_id(b_res_id), .res_words(b_words)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int u, input int id, input int words, input int par);
        exp_t e;
        e.id = id; e.words = words; e.par = par;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_check(input int u, input logic p, input logic [1:0] id, input logic [7:0] w);
        exp_t e;
        int   sz;
        sz = (u == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result u%0d: got id %0d words %0d, expected none", u, id, w);
        end else begin
            if (u == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("u%0d_res_id", u), {30'd0, id}, e.id);
            check($sformatf("u%0d_res_words", u), {24'd0, w}, e.words);
            check($sformatf("u%0d_res_parity", u), {31'd0, p}, e.par);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n && a_res_valid && res_ready[0]) pop_check(0, a_res_parity, a_res_id, a_words);
        if (rst_n && b_res_valid && res_ready[1]) pop_check(1, b_res_parity, b_res_id, {6'd0, b_words});
    end

    // Present one word and hold it until the DUT takes it; call just after a rising edge.
    task automatic send(input int u, input int r, input logic [15:0] d, input logic l);
        int           n;
        logic         hs;
        logic [3:0]   rdy;
        valid[u][r] = 1'b1;
        data[u][r*DW +: DW] = d;
        last[u][r] = l;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 200) begin
            @(negedge clk);
            rdy = (u == 0) ? a_ready : b_ready;
            hs  = rdy[r];
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout u%0d r%0d: got no ready, expected ready within 200 cycles", u, r);
        end
        valid[u][r] = 1'b0;
        last[u][r]  = 1'b0;
    endtask

    task automatic drain(input int u);
        int n;
        n = 0;
        while (((u == 0) ? q0.size() : q1.size()) > 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (((u == 0) ? q0.size() : q1.size()) > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout u%0d: got %0d pending, expected 0", u,
                     (u == 0) ? q0.size() : q1.size());
            if (u == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            valid[u] = '0;
            last[u]  = '0;
            data[u]  = '0;
            res_ready[u] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", {31'd0, a_res_valid}, 0);
        check("rst_res_parity", {31'd0, a_res_parity}, 0);
        check("rst_res_id", {30'd0, a_res_id}, 0);
        check("rst_res_words", {24'd0, a_words}, 0);
        check("rst_req_ready", {28'd0, a_ready}, 0);
        check("rst_b_res_valid", {31'd0, b_res_valid}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-word frame straight after reset: arbitration edge, then accept edge.
        push(0, 0, 1, 1);
        lat = 0;
        fork
            send(0, 0, 16'h0001, 1'b1);
            begin
                do begin
                    @(posedge clk);
                    #1;
                    lat++;
                end while (!a_res_valid && lat < 20);
            end
        join
        check("first_latency", lat, 2);
        drain(0);

        // Three-word frame, 19 set bits.
        push(0, 2, 3, 1);
        send(0, 2, 16'hFFFF, 1'b0);
        send(0, 2, 16'h0003, 1'b0);
        send(0, 2, 16'h0100, 1'b1);
        drain(0);

        // Reset while req1 is mid-frame; the partial frame must vanish.
        send(0, 1, 16'h0F00, 1'b0);
        send(0, 1, 16'h0001, 1'b0);
        check("midframe_ready", {28'd0, a_ready}, 32'h2);
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", {28'd0, a_ready}, 0);
        check("arst_res_valid", {31'd0, a_res_valid}, 0);
        check("arst_res_parity", {31'd0, a_res_parity}, 0);
        check("arst_res_id", {30'd0, a_res_id}, 0);
        check("arst_res_words", {24'd0, a_words}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(0, 3, 1, 0);
        send(0, 3, 16'h0101, 1'b1);
        drain(0);

        // All requesters continuously offering one-word frames.
        push(0, 0, 1, 0);
        push(0, 1, 1, 0);
        push(0, 2, 1, 1);
        push(0, 3, 1, 0);
        push(0, 0, 1, 0);
        push(0, 1, 1, 0);
        data[0] = {16'hF00F, 16'h0007, 16'h0003, 16'h0000};
        last[0] = 4'hF;
        valid[0] = 4'hF;
        drain(0);
        valid[0] = '0;
        last[0]  = '0;

        // Result stalled for five cycles, with competitors waiting; req2 wins next, then req0.
        res_ready[0] = 1'b0;
        push(0, 1, 2, 0);
        push(0, 2, 1, 1);
        push(0, 0, 1, 1);
        send(0, 1, 16'h1234, 1'b0);
        send(0, 1, 16'h0001, 1'b1);
        fork
            send(0, 0, 16'h0010, 1'b1);
            send(0, 2, 16'h0007, 1'b1);
            begin
                for (int c = 1; c <= 5; c++) begin
                    @(negedge clk);
                    check($sformatf("hold%0d_valid", c), {31'd0, a_res_valid}, 1);
                    check($sformatf("hold%0d_id", c), {30'd0, a_res_id}, 1);
                    check($sformatf("hold%0d_words", c), {24'd0, a_words}, 2);
                    check($sformatf("hold%0d_parity", c), {31'd0, a_res_parity}, 0);
                    check($sformatf("hold%0d_req_ready", c), {28'd0, a_ready}, 0);
                end
                @(posedge clk);
                #1;
                res_ready[0] = 1'b1;
            end
        join
        drain(0);

        // Odd-parity, 2-bit-counter instance: 19 set bits, then a saturating 6-word frame with gaps.
        push(1, 2, 3, 0);
        send(1, 2, 16'hFFFF, 1'b0);
        send(1, 2, 16'h0003, 1'b0);
        send(1, 2, 16'h0100, 1'b1);
        drain(1);
        push(1, 1, 3, 1);
        for (int i = 0; i < 6; i++) begin
            send(1, 1, 16'h8000, (i == 5));
            if (i < 5) begin
                repeat (3) @(posedge clk);
                #1;
            end
        end
        drain(1);

        repeat (5) @(posedge clk);
        check("leftover_q0", q0.size(), 0);
        check("leftover_q1", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
